// File: rtl/basilisk_pkg.sv
// Shared types and constants for the basilisk floating-point unit.
package basilisk_pkg;

   localparam logic signed [9:0] BASILISK_EXP_BIAS    = 10'sd127;
   localparam logic signed [9:0] BASILISK_EXP_SPECIAL = 10'sd128;

   typedef enum logic [2:0] {
      BASILISK_OP_ADD  = 3'd0,
      BASILISK_OP_SUB  = 3'd1,
      BASILISK_OP_MUL  = 3'd2,
      BASILISK_OP_FMA  = 3'd3,
      BASILISK_OP_DIV  = 3'd4,
      BASILISK_OP_SQRT = 3'd5,
      BASILISK_OP_MIN  = 3'd6,
      BASILISK_OP_MAX  = 3'd7
   } basilisk_math_op_t;

   typedef struct packed {
      logic                sign;
      logic signed [9:0]   exp;
      logic [23:0]         mant;
      logic                zero;
      logic                inf;
      logic                nan;
      logic                snan;
   } basilisk_unpacked_t;

   typedef struct packed {
      logic [4:0]          dest_reg_addr;
      basilisk_math_op_t   op;
      logic [2:0]          rounding_mode;
      logic [31:0]         a;
      logic [31:0]         b;
      logic [31:0]         c;
   } basilisk_decode_command_t;

   typedef struct packed {
      logic [4:0]          dest_reg_addr;
      basilisk_math_op_t   op;
      logic [2:0]          rounding_mode;
      basilisk_unpacked_t  a;
      basilisk_unpacked_t  b;
      basilisk_unpacked_t  c;
   } basilisk_decoded_command_t;

   // Per-operand state captured between the classify and adjust halves.
   typedef struct packed {
      logic                sign;
      logic [7:0]          e;
      logic [22:0]         f;
      logic                zero;
      logic                inf;
      logic                nan;
      logic                snan;
      logic                sub;
      logic [4:0]          lz;
   } basilisk_s1_operand_t;

endpackage

// File: rtl/basilisk_unpack_operand.sv
// Classifies one raw binary32 operand (stage 1) and normalizes it into
// sign / unbiased exponent / 24-bit mantissa form (stage 2).
module basilisk_unpack_operand
   import basilisk_pkg::*;
(
   input  logic [31:0]          raw,
   output basilisk_s1_operand_t s1,
   input  basilisk_s1_operand_t s1_q,
   output basilisk_unpacked_t   unpacked
);

   function automatic logic [4:0] lzc23(input logic [22:0] f);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 23; i++)
         if (f[i]) n = 5'(22 - i);
      return n;
   endfunction

   always_comb begin : classify
      s1      = '0;
      s1.sign = raw[31];
      s1.e    = raw[30:23];
      s1.f    = raw[22:0];
      s1.zero = (raw[30:23] == 8'h00) && (raw[22:0] == 23'd0);
      s1.sub  = (raw[30:23] == 8'h00) && (raw[22:0] != 23'd0);
      s1.inf  = (raw[30:23] == 8'hff) && (raw[22:0] == 23'd0);
      s1.nan  = (raw[30:23] == 8'hff) && (raw[22:0] != 23'd0);
      s1.snan = s1.nan && !raw[22];
      s1.lz   = lzc23(raw[22:0]);
   end

   always_comb begin : adjust
      unpacked      = '0;
      unpacked.sign = s1_q.sign;
      unpacked.zero = s1_q.zero;
      unpacked.inf  = s1_q.inf;
      unpacked.nan  = s1_q.nan;
      unpacked.snan = s1_q.snan;
      if (s1_q.zero) begin
         unpacked.exp  = '0;
         unpacked.mant = '0;
      end else if (s1_q.inf || s1_q.nan) begin
         // Infinity has F=0, so {1,F} yields 0x800000 for it as well.
         unpacked.exp  = BASILISK_EXP_SPECIAL;
         unpacked.mant = {1'b1, s1_q.f};
      end else if (s1_q.sub) begin
         unpacked.exp  = -BASILISK_EXP_BIAS - $signed({5'b00000, s1_q.lz});
         unpacked.mant = {s1_q.f, 1'b0} << s1_q.lz;
      end else begin
         unpacked.exp  = $signed({2'b00, s1_q.e}) - BASILISK_EXP_BIAS;
         unpacked.mant = {1'b1, s1_q.f};
      end
   end

endmodule

// File: rtl/basilisk_decode.sv
// Operand-unpack stage: two-stage valid/ready pipeline around three
// operand unpackers, with passthrough of the command control fields.
module basilisk_decode
   import basilisk_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      decode_command_valid,
   output logic                      decode_command_ready,
   input  basilisk_decode_command_t  decode_command_data,
   output logic                      decoded_command_valid,
   input  logic                      decoded_command_ready,
   output basilisk_decoded_command_t decoded_command_data
);

   logic                 s1_valid;
   logic                 s2_valid;
   logic                 s1_ready;
   logic                 s2_ready;
   logic [4:0]           s1_dest;
   basilisk_math_op_t    s1_op;
   logic [2:0]           s1_rm;
   logic [31:0]          raw  [3];
   basilisk_s1_operand_t s1_d [3];
   basilisk_s1_operand_t s1_q [3];
   basilisk_unpacked_t   up   [3];

   assign raw[0] = decode_command_data.a;
   assign raw[1] = decode_command_data.b;
   assign raw[2] = decode_command_data.c;

   for (genvar g = 0; g < 3; g++) begin : g_op
      basilisk_unpack_operand u_unpack (
         .raw      (raw[g]),
         .s1       (s1_d[g]),
         .s1_q     (s1_q[g]),
         .unpacked (up[g])
      );
   end

   assign s2_ready              = !s2_valid || decoded_command_ready;
   assign s1_ready              = !s1_valid || s2_ready;
   assign decode_command_ready  = s1_ready && rst;
   assign decoded_command_valid = s2_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_dest  <= '0;
         s1_op    <= BASILISK_OP_ADD;
         s1_rm    <= '0;
         for (int i = 0; i < 3; i++) s1_q[i] <= '0;
      end else if (s1_ready) begin
         s1_valid <= decode_command_valid;
         if (decode_command_valid) begin
            s1_dest <= decode_command_data.dest_reg_addr;
            s1_op   <= decode_command_data.op;
            s1_rm   <= decode_command_data.rounding_mode;
            for (int i = 0; i < 3; i++) s1_q[i] <= s1_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid             <= 1'b0;
         decoded_command_data <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            decoded_command_data.dest_reg_addr <= s1_dest;
            decoded_command_data.op            <= s1_op;
            decoded_command_data.rounding_mode <= s1_rm;
            decoded_command_data.a             <= up[0];
            decoded_command_data.b             <= up[1];
            decoded_command_data.c             <= up[2];
         end
      end
   end

endmodule

// File: tb/tb_basilisk_decode.sv
// Self-checking bench for basilisk_decode: directed vectors plus random
// streams scored against an arithmetic model of binary32 unpacking.
module tb_basilisk_decode;
   import basilisk_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      decode_command_valid;
   logic                      decode_command_ready;
   basilisk_decode_command_t  decode_command_data;
   logic                      decoded_command_valid;
   logic                      decoded_command_ready;
   basilisk_decoded_command_t decoded_command_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int out_cnt = 0;
   int run = 0;
   int max_run = 0;
   bit chk_lat = 0;
   bit prev_stall = 0;
   basilisk_decoded_command_t prev_data;
   basilisk_decoded_command_t sb[$];
   int acc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   basilisk_decode dut (
      .clk                   (clk),
      .rst                   (rst),
      .decode_command_valid  (decode_command_valid),
      .decode_command_ready  (decode_command_ready),
      .decode_command_data   (decode_command_data),
      .decoded_command_valid (decoded_command_valid),
      .decoded_command_ready (decoded_command_ready),
      .decoded_command_data  (decoded_command_data)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic basilisk_unpacked_t ref_unpack(input logic [31:0] raw);
      basilisk_unpacked_t u;
      int e, f, m, x;
      u = '0;
      u.sign = raw[31];
      e = int'(raw[30:23]);
      f = int'(raw[22:0]);
      if (e == 255) begin
         u.exp  = 10'(128);
         u.mant = 24'(f + (1 << 23));
         u.inf  = (f == 0);
         u.nan  = (f != 0);
         u.snan = (f != 0) && (f < (1 << 22));
      end else if (e == 0 && f == 0) begin
         u.zero = 1'b1;
      end else if (e == 0) begin
         // value = f * 2^-149; double until the hidden-one position is reached
         m = f;
         x = -126;
         while (m < (1 << 23)) begin
            m = m * 2;
            x = x - 1;
         end
         u.exp  = 10'(x);
         u.mant = 24'(m);
      end else begin
         u.exp  = 10'(e - 127);
         u.mant = 24'(f + (1 << 23));
      end
      return u;
   endfunction

   function automatic basilisk_decoded_command_t ref_decode(input basilisk_decode_command_t c);
      basilisk_decoded_command_t d;
      d.dest_reg_addr = c.dest_reg_addr;
      d.op            = c.op;
      d.rounding_mode = c.rounding_mode;
      d.a = ref_unpack(c.a);
      d.b = ref_unpack(c.b);
      d.c = ref_unpack(c.c);
      return d;
   endfunction

   function automatic basilisk_unpacked_t mk(input bit s, input int e, input logic [23:0] m,
                                             input bit z, input bit i, input bit n, input bit sn);
      basilisk_unpacked_t u;
      u.sign = s; u.exp = 10'(e); u.mant = m;
      u.zero = z; u.inf = i; u.nan = n; u.snan = sn;
      return u;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         1: r[30:23] = 8'h00;
         2: r[30:23] = 8'hff;
         3: begin r[30:23] = 8'h00; r[22:0] = r[22:0] >> $urandom_range(0, 22); end
         4: if ($urandom_range(0, 1) == 1) r[22:0] = '0;
         default: ;
      endcase
      return r;
   endfunction

   function automatic basilisk_decode_command_t rand_cmd();
      basilisk_decode_command_t c;
      c.dest_reg_addr = 5'($urandom);
      c.op            = basilisk_math_op_t'(3'($urandom));
      c.rounding_mode = 3'($urandom);
      c.a = rand_operand();
      c.b = rand_operand();
      c.c = rand_operand();
      return c;
   endfunction

   // Scoreboard / protocol monitor, sampled mid-cycle before the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         acc.delete();
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 128'(decoded_command_valid), 128'(1));
            chk("stall_data", 128'(decoded_command_data), 128'(prev_data));
         end
         if (decoded_command_valid && decoded_command_ready) begin
            chk("out_pending", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
               chk("out_data", 128'(decoded_command_data), 128'(sb.pop_front()));
               if (chk_lat) chk("latency", 128'(cyc + 1 - acc[0]), 128'(2));
               void'(acc.pop_front());
            end
            out_cnt++;
         end
         if (decode_command_valid && decode_command_ready) begin
            sb.push_back(ref_decode(decode_command_data));
            acc.push_back(cyc + 1);
         end
         prev_stall = decoded_command_valid && !decoded_command_ready;
         prev_data  = decoded_command_data;
      end
      run = decoded_command_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
   end

   task automatic send(input basilisk_decode_command_t c, output int waits);
      decode_command_valid = 1'b1;
      decode_command_data  = c;
      waits = 0;
      @(negedge clk);
      while (!decode_command_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      chk("send_timeout", 128'(waits < 200), 128'(1));
      @(posedge clk); #1;
      decode_command_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 128'(sb.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input basilisk_unpacked_t ea, input basilisk_unpacked_t eb,
                           input basilisk_unpacked_t ec);
      basilisk_decode_command_t cmd;
      cmd = rand_cmd();
      cmd.a = a; cmd.b = b; cmd.c = c;
      decode_command_valid = 1'b1;
      decode_command_data  = cmd;
      @(negedge clk);
      chk("dir_in_ready", 128'(decode_command_ready), 128'(1));
      @(posedge clk); #1;
      decode_command_valid = 1'b0;
      @(negedge clk);
      chk("dir_valid_n1", 128'(decoded_command_valid), 128'(0));
      @(negedge clk);
      chk("dir_valid_n2", 128'(decoded_command_valid), 128'(1));
      chk("dir_a", 128'(decoded_command_data.a), 128'(ea));
      chk("dir_b", 128'(decoded_command_data.b), 128'(eb));
      chk("dir_c", 128'(decoded_command_data.c), 128'(ec));
      chk("dir_dest", 128'(decoded_command_data.dest_reg_addr), 128'(cmd.dest_reg_addr));
      @(posedge clk); #1;
   endtask

   initial begin
      int w;
      int base;
      bit bp_done;
      logic [3:0] pat;
      basilisk_unpacked_t zp;

      rst = 1'b0;
      decode_command_valid = 1'b0;
      decode_command_data = '0;
      decoded_command_ready = 1'b1;
      zp = mk(0, 0, 24'h0, 1, 0, 0, 0);
      #1;
      chk("reset_out_valid", 128'(decoded_command_valid), 128'(0));
      chk("reset_in_ready", 128'(decode_command_ready), 128'(0));
      chk("reset_out_data", 128'(decoded_command_data), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      directed(32'h3F800000, 32'hC0490FDB, 32'h00000000,
               mk(0, 0, 24'h800000, 0, 0, 0, 0), mk(1, 1, 24'hC90FDB, 0, 0, 0, 0), zp);
      directed(32'h00400000, 32'h00000001, 32'h00000003,
               mk(0, -127, 24'h800000, 0, 0, 0, 0), mk(0, -149, 24'h800000, 0, 0, 0, 0),
               mk(0, -148, 24'hC00000, 0, 0, 0, 0));
      directed(32'h80000000, 32'h7F800000, 32'h7FA00001,
               mk(1, 0, 24'h0, 1, 0, 0, 0), mk(0, 128, 24'h800000, 0, 1, 0, 0),
               mk(0, 128, 24'hA00001, 0, 0, 1, 1));
      directed(32'h7FC00000, 32'h00000000, 32'hFF800000,
               mk(0, 128, 24'hC00000, 0, 0, 1, 0), zp, mk(1, 128, 24'h800000, 0, 1, 0, 0));

      // Backpressure: output ready cycles 1,0,0,1 while inputs arrive with random gaps.
      base = out_cnt;
      bp_done = 0;
      pat = 4'b1001;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send(rand_cmd(), w);
            end
            bp_done = 1;
         end
         begin
            int k = 0;
            while (!bp_done) begin
               decoded_command_ready = pat[3 - (k % 4)];
               k++;
               @(posedge clk); #1;
            end
         end
      join
      decoded_command_ready = 1'b1;
      drain();
      chk("bp_count", 128'(out_cnt - base), 128'(8));

      // Full throughput: 16 back-to-back commands, no bubbles in or out.
      repeat (3) begin @(posedge clk); #1; end
      base = out_cnt;
      max_run = 0;
      chk_lat = 1;
      for (int i = 0; i < 16; i++) begin
         send(rand_cmd(), w);
         chk("tput_in_ready", 128'(w), 128'(0));
      end
      drain();
      chk_lat = 0;
      chk("tput_count", 128'(out_cnt - base), 128'(16));
      chk("tput_run", 128'(max_run), 128'(16));

      // Reset mid-flight with both stages full and the output stalled.
      decoded_command_ready = 1'b0;
      send(rand_cmd(), w);
      send(rand_cmd(), w);
      @(negedge clk);
      chk("full_in_ready", 128'(decode_command_ready), 128'(0));
      chk("full_out_valid", 128'(decoded_command_valid), 128'(1));
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 128'(decoded_command_valid), 128'(0));
      chk("rst_in_ready", 128'(decode_command_ready), 128'(0));
      chk("rst_out_data", 128'(decoded_command_data), 128'(0));
      @(posedge clk); #3;
      rst = 1'b1;
      decoded_command_ready = 1'b1;
      base = out_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_no_stale", 128'(decoded_command_valid), 128'(0));
      end
      @(posedge clk); #1;
      send(rand_cmd(), w);
      drain();
      chk("post_rst_count", 128'(out_cnt - base), 128'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
